// File: rtl/seven_seg_scan_if.sv
// Control and pin-side signals of the multiplexed 7-segment scanner.
// The master drives value/control; the slave (scanner) drives the display pins.
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output enable, load, value, dp_in, lz_blank,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  enable, load, value, dp_in, lz_blank,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed DIGITS-wide 7-segment driver with double-buffered value,
// per-digit decimal points, leading-zero blanking and anti-ghosting dark cycles.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK          = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic             clk,
  input logic             rst,
  seven_seg_scan_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF     = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick_q, tick_d;

  logic                frame_end;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                all_zero;
  logic                lit;
  logic [6:0]          seg_on;
  logic [DIGITS-1:0]   an_hot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign frame_end = bus.enable && (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (bus.enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // Transfer sees pending from before this edge; a coincident load re-arms for next frame.
    if (frame_end && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (bus.load) begin
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    all_zero  = 1'b1;
    an_hot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        an_hot[i] = 1'b1;
      end
    end
    // Walk down from the top digit; a digit is blanked while everything above it is zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (disp_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) cur_blank = bus.lz_blank && all_zero;
    end
    lit    = bus.enable && !(int'(presc_q) < BLANK);
    seg_on = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    an_d   = AN_OFF;
    tick_d = frame_end;
    if (lit) begin
      seg_d = seg_on ^ SEG_OFF;
      dp_d  = cur_dp ^ DP_OFF;
      an_d  = an_hot ^ AN_OFF;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode/common-cathode 7-segment display. It holds a hex value in a double-buffered register and scans one digit per slot from an internal prescaler. It also provides per-digit decimal points, optional leading-zero blanking and anti-ghosting blank cycles. It sits between the register/status logic and the board display pins, and supersedes the single-digit combinational decoder for multi-digit boards.

## Interface

Parameters:
- DIGITS, 4, number of digits; ≥1
- CLK_DIV, 50000, clk cycles per digit slot; ≥2
- BLANK, 1, cycles at the start of each slot with all anodes inactive; 0 ≤ BLANK < CLK_DIV
- SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit
- AN_ACTIVE_LOW, 1, 1: an driven low = digit selected

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1: scan runs; 0: display dark, counters hold
- load  in  1  one-cycle strobe: capture value/dp_in into pending buffer
- value  in  4*DIGITS  hex nibbles; nibble i = digit i, digit 0 = least significant (rightmost)
- dp_in  in  DIGITS  decimal point per digit
- lz_blank  in  1  leading-zero blanking enable (sampled live)
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point, registered
- an  out  DIGITS  digit select, one-hot active or all inactive, registered
- frame_tick  out  1  one-cycle pulse at end of each full scan, registered

## Operation

- State: prescaler presc (0..CLK_DIV-1), digit index idx (0..DIGITS-1), pending value/dp regs, pend_valid flag, display value/dp regs.
- Reset (async, immediate): presc=0, idx=0, all buffers 0, pend_valid=0; an = all inactive; seg and dp = unlit; frame_tick=0.
- Load: load=1 in any cycle writes value/dp_in to pending and sets pend_valid. Back-to-back loads: the last one wins.
- Tear-free update: at the frame-end cycle (enable=1, presc=CLK_DIV-1, idx=DIGITS-1), if pend_valid then display ← pending, pend_valid ← 0.
  - If load coincides with frame end, the transfer uses pending contents from before that edge. The new load lands in pending and pend_valid stays 1 for the next frame.
- Scan: with enable=1, presc increments each cycle. At presc=CLK_DIV-1, presc wraps to 0 and idx increments, wrapping DIGITS-1 → 0.
- enable=0: presc/idx hold, no transfer, an all inactive, seg/dp unlit, frame_tick=0. Loads are still accepted.
- Decode (active-high form, inverted when SEG_ACTIVE_LOW=1): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking: with lz_blank=1, digit i≥1 is blanked if display nibbles DIGITS-1..i are all zero. Digit 0 is never blanked.
  - A blanked digit has seg unlit but anode still selected; dp still follows the dp bit.
- Ghost suppression: while presc < BLANK, an is all inactive and seg/dp are unlit.

## Timing

- All outputs are registered. Outputs in cycle t reflect presc/idx/display/enable of cycle t-1 (1-cycle latency).
- First rising edge after rst deasserts with enable=1: outputs still show state idx=0, presc=0. Digit 0 anode is asserted after the edge on which presc reaches BLANK.
- Each slot lasts CLK_DIV cycles: BLANK dark cycles, then CLK_DIV-BLANK cycles with an[idx] active.
- Full frame = DIGITS*CLK_DIV cycles.
- frame_tick is high for exactly one cycle: the cycle after the frame-end edge. The display registers update on that same edge.
- Load-to-visible latency: up to DIGITS*CLK_DIV+1 cycles, never mid-frame.
- rst asserted mid-frame: outputs go inactive immediately (asynchronously), and pending/display are cleared.

## Test plan

Parameters for all scenarios: DIGITS=4, CLK_DIV=4, BLANK=1, both active-low.
- Reset: assert rst mid-scan → same delta: an=4'hF, seg=7'h7F, dp=1, frame_tick=0. After release, the first anode (an=4'hE) appears on the 2nd rising edge.
- Scan and decode: load value=16'h12AF, dp_in=4'b0100, wait for frame_tick. Then per slot: an=E seg=~71, an=D seg=~77, an=B seg=~5B dp=0, an=7 seg=~06. Each anode active 3 cycles, 1 dark cycle between slots; frame_tick period is 16 cycles.
- Tear-free update: load 16'h1111, then 16'h2222 mid-frame → the current frame still shows the old digits throughout, only 2s appear after the next frame_tick, and 1s never appear.
- Load at frame-end cycle: load 16'h3333 at frame end while pending holds 16'h4444 → the next frame shows 4s and the following frame shows 3s.
- Leading-zero blanking: value=16'h0050, lz_blank=1 → digits 3 and 2 have an active with seg=7'h7F, digit 1 shows 5, and digit 0 shows 0. With value=16'h0000, only digit 0 is lit.
- Enable: drop enable for 10 cycles mid-slot → an=4'hF, no frame_tick, and presc/idx resume from the held values when enable returns.
